// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter and sequencer for one shared
// accumulator register. Each op takes three cycles: arbitrate and latch
// (IDLE), execute (EXEC), respond (RESP).
//
// Handshake: a requester raises req[i] with op/wdata stable, and holds it
// until it sees done[i]. grant[i] pulses when the request is accepted. done[i]
// pulses with result valid. req must be low by the edge that ends the done
// cycle, otherwise it counts as a fresh request in the next IDLE.
module shared_reg_arbiter #(
  parameter int                 NUM_REQ     = 4,
  parameter int                 DATA_W      = 32,
  parameter logic [DATA_W-1:0]  RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [2*NUM_REQ-1:0]        op,
  input  logic [DATA_W*NUM_REQ-1:0]   wdata,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic [DATA_W-1:0]           result,
  output logic [DATA_W-1:0]           acc_out,
  output logic                        busy,
  output logic [1:0]                  dbgState
);

  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state, nextState;
  logic [OW-1:0]       owner, lastOwner, winner;
  logic                found;
  logic [1:0]          opLat;
  logic [DATA_W-1:0]   wdataLat, acc, newAcc;
  logic [NUM_REQ-1:0]  grantNext, doneNext;

  // State register; reset lands in IDLE and aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic: fixed three-step sequence once a request is seen.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (found) nextState = EXEC;
      EXEC:    nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Round-robin pick: first set req bit after lastOwner, wrapping around.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req[(int'(lastOwner) + i) % NUM_REQ]) begin
        found  = 1'b1;
        winner = OW'((int'(lastOwner) + i) % NUM_REQ);
      end
    end
  end

  // Output logic: next grant/done pulses and the busy flag.
  always_comb begin
    grantNext = '0;
    doneNext  = '0;
    busy      = 1'b0;
    case (state)
      IDLE: if (found) grantNext = NUM_REQ'(1) << winner;
      EXEC: begin
        doneNext = NUM_REQ'(1) << owner;
        busy     = 1'b1;
      end
      RESP: busy = 1'b1;
      default: ;
    endcase
  end

  // Accumulator update for the latched op; wraps modulo 2^DATA_W.
  always_comb begin
    newAcc = acc;
    case (opLat)
      2'b00:   newAcc = wdataLat;
      2'b01:   newAcc = acc + DATA_W'(1);
      2'b10:   newAcc = acc - DATA_W'(1);
      default: newAcc = acc;
    endcase
  end

  // Datapath registers: latch the winner's op in IDLE, commit it in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      done      <= '0;
      result    <= '0;
      acc       <= RESET_VALUE;
      lastOwner <= OW'(NUM_REQ - 1);
      owner     <= '0;
      opLat     <= '0;
      wdataLat  <= '0;
    end else begin
      grant <= grantNext;
      done  <= doneNext;
      if (state == IDLE && found) begin
        owner    <= winner;
        opLat    <= op[2*int'(winner) +: 2];
        wdataLat <= wdata[DATA_W*int'(winner) +: DATA_W];
      end
      if (state == EXEC) begin
        acc       <= newAcc;
        result    <= newAcc;
        lastOwner <= owner;
      end
    end
  end

  assign acc_out  = acc;
  assign dbgState = state;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: inputs change and outputs are
// checked on the falling edge, away from the active rising edge.
module tb_shared_reg_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [2*NR-1:0]   op;
  logic [DW*NR-1:0]  wdata;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic [DW-1:0]     result;
  logic [DW-1:0]     acc_out;
  logic              busy;
  logic [1:0]        dbgState;

  int passCnt  = 0;
  int totalCnt = 0;
  logic [DW-1:0] exp_q[$];

  shared_reg_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .RESET_VALUE('0)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata),
    .grant(grant), .done(done), .result(result), .acc_out(acc_out),
    .busy(busy), .dbgState(dbgState)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    totalCnt++;
    assert (obs === expv) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // driver: one full single-requester op with its latency checked cycle by cycle
  task automatic doOp(input int idx, input logic [1:0] opc, input logic [DW-1:0] data,
                      input logic [DW-1:0] expRes, input string tag);
    req = '0;
    req[idx] = 1'b1;
    op[2*idx +: 2] = opc;
    wdata[DW*idx +: DW] = data;
    exp_q.push_back(expRes);
    tick();
    check({tag, "_grant"}, grant, 64'(1) << idx);
    check({tag, "_nodone"}, done, 0);
    req = '0;
    tick();
    check({tag, "_done"}, done, 64'(1) << idx);
    check({tag, "_grant0"}, grant, 0);
    check({tag, "_result"}, result, exp_q.pop_front());
    check({tag, "_acc"}, acc_out, expRes);
    tick();
    check({tag, "_idle"}, dbgState, 0);
  endtask

  initial begin
    rst   = 1'b0;
    req   = '0;
    op    = '0;
    wdata = '0;

    // 1: asynchronous reset asserted mid-cycle clears outputs at once
    #3 rst = 1'b1;
    #1;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_acc", acc_out, 0);
    check("rst_busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rel_state", dbgState, 0);
    check("rel_busy", busy, 0);

    // 2: single LOAD, grant at t+1, done/result at t+2
    req = 4'b0100;
    op[5:4] = 2'b00;
    wdata[2*DW +: DW] = 32'h1234;
    tick();
    check("lat_grant", grant, 4'b0100);
    check("lat_busy_exec", busy, 1);
    check("lat_state_exec", dbgState, 1);
    req = '0;
    tick();
    check("lat_done", done, 4'b0100);
    check("lat_result", result, 32'h1234);
    check("lat_acc", acc_out, 32'h1234);
    check("lat_state_resp", dbgState, 2);
    tick();
    check("lat_done_clr", done, 0);
    check("lat_busy_idle", busy, 0);

    // 3: wrap at both ends
    doOp(1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "wrap_load");
    doOp(0, 2'b01, 32'h0, 32'h0, "wrap_inc");
    doOp(3, 2'b10, 32'h0, 32'hFFFF_FFFF, "wrap_dec");

    // 4: round robin with all four requesting INC from 0
    resetDut();
    op  = 8'b01_01_01_01;
    req = 4'b1111;
    for (int k = 1; k <= 5; k++) exp_q.push_back(DW'(k));
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_grant", grant, 64'(1) << (k % 4));
      tick();
      check("rr_done", done, 64'(1) << (k % 4));
      check("rr_result", result, exp_q.pop_front());
      if (k == 4) req = '0;
      tick();
      check("rr_nodone_idle", done, 0);
    end
    check("rr_acc", acc_out, 5);

    // 5: op/wdata changes after the IDLE sample are ignored; READ keeps acc
    req = 4'b0001;
    op[1:0] = 2'b00;
    wdata[0 +: DW] = 32'hAAAA_0000;
    tick();
    check("late_grant", grant, 4'b0001);
    op[1:0] = 2'b01;
    wdata[0 +: DW] = 32'h5555;
    req = '0;
    tick();
    check("late_result", result, 32'hAAAA_0000);
    check("late_acc", acc_out, 32'hAAAA_0000);
    tick();
    doOp(2, 2'b11, 32'h0, 32'hAAAA_0000, "read");

    // 6: reset during EXEC aborts the op and restores lastOwner
    doOp(1, 2'b00, 32'd5, 32'd5, "pre_load");
    req = 4'b0100;
    op[5:4] = 2'b01;
    tick();
    check("abort_grant", grant, 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("abort_acc", acc_out, 0);
    check("abort_done", done, 0);
    check("abort_grant0", grant, 0);
    check("abort_state", dbgState, 0);
    req = '0;
    tick();
    rst = 1'b0;
    tick();
    check("abort_nodone", done, 0);
    check("abort_acc_hold", acc_out, 0);
    req = 4'b0110;
    op[3:2] = 2'b01;
    tick();
    check("post_rst_grant", grant, 4'b0010);
    req = '0;
    tick();
    check("post_rst_done", done, 4'b0010);
    check("post_rst_result", result, 1);
    tick();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
